// File: rtl/sram_read_sequencer.sv
// SRAM read sequencer: precharge -> wordline develop -> sense/capture -> response handshake.
// All array-facing enables are registered and change together with the state register.
module sram_read_sequencer #(
  parameter int ADDR_W        = 5,
  parameter int DATA_W        = 8,
  parameter int PRECHARGE_CYC = 1,
  parameter int SENSE_CYC     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              precharge_en,
  output logic              wl_en,
  output logic [ADDR_W-1:0] wl_addr,
  output logic              sa_en,
  input  logic [DATA_W-1:0] sa_data,
  output logic              busy
);

  // state     | meaning
  // IDLE      | waiting for a request, req_ready=1
  // PRECHARGE | bitlines equalized for PRECHARGE_CYC cycles
  // WORDLINE  | wordline on, bitlines develop for SENSE_CYC cycles
  // SENSE     | wordline + sense amp on, sa_data captured at the closing edge
  // RESP      | rsp_valid held until rsp_ready
  typedef enum logic [2:0] {IDLE, PRECHARGE, WORDLINE, SENSE, RESP} state_t;

  localparam logic [3:0] PC_LOAD = 4'(PRECHARGE_CYC - 1);
  localparam logic [3:0] SC_LOAD = 4'(SENSE_CYC - 1);

  state_t     state;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      precharge_en <= 1'b0;
      wl_en        <= 1'b0;
      sa_en        <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      wl_addr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            wl_addr      <= req_addr;
            cnt          <= PC_LOAD;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
            precharge_en <= 1'b1;
            state        <= PRECHARGE;
          end
        end
        PRECHARGE: begin
          // precharge_en drops on the same edge wl_en rises, so they never overlap
          if (cnt == 4'd0) begin
            cnt          <= SC_LOAD;
            precharge_en <= 1'b0;
            wl_en        <= 1'b1;
            state        <= WORDLINE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WORDLINE: begin
          if (cnt == 4'd0) begin
            sa_en <= 1'b1;
            state <= SENSE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SENSE: begin
          rsp_data  <= sa_data;
          sa_en     <= 1'b0;
          wl_en     <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_read_sequencer.sv
// Directed bench for sram_read_sequencer: default instance plus a PRECHARGE_CYC=3/SENSE_CYC=4 instance,
// with a scoreboard queue of expected read words.
module tb_sram_read_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [4:0] req_addr;
  logic       rsp_ready;
  bit         sel;

  logic       a_req_valid, a_req_ready, a_rsp_valid, a_pc, a_wl, a_sa, a_busy;
  logic [7:0] a_rsp_data, a_sa_data;
  logic [4:0] a_wl_addr;
  logic       b_req_valid, b_req_ready, b_rsp_valid, b_pc, b_wl, b_sa, b_busy;
  logic [7:0] b_rsp_data, b_sa_data;
  logic [4:0] b_wl_addr;

  logic [7:0] mem [32];
  logic [7:0] sb [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign a_req_valid = req_valid & ~sel;
  assign b_req_valid = req_valid & sel;

  always_comb a_sa_data = a_sa ? mem[a_wl_addr] : 8'h00;
  always_comb b_sa_data = b_sa ? mem[b_wl_addr] : 8'h00;

  sram_read_sequencer dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .precharge_en(a_pc),
    .wl_en(a_wl), .wl_addr(a_wl_addr), .sa_en(a_sa), .sa_data(a_sa_data), .busy(a_busy)
  );

  sram_read_sequencer #(.PRECHARGE_CYC(3), .SENSE_CYC(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data), .precharge_en(b_pc),
    .wl_en(b_wl), .wl_addr(b_wl_addr), .sa_en(b_sa), .sa_data(b_sa_data), .busy(b_busy)
  );

  logic       o_req_ready, o_rsp_valid, o_pc, o_wl, o_sa, o_busy;
  logic [7:0] o_rsp_data;
  logic [4:0] o_wl_addr;
  assign o_req_ready = sel ? b_req_ready : a_req_ready;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_pc        = sel ? b_pc : a_pc;
  assign o_wl        = sel ? b_wl : a_wl;
  assign o_sa        = sel ? b_sa : a_sa;
  assign o_busy      = sel ? b_busy : a_busy;
  assign o_rsp_data  = sel ? b_rsp_data : a_rsp_data;
  assign o_wl_addr   = sel ? b_wl_addr : a_wl_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full read on the selected instance; hold = cycles of rsp_ready=0 once rsp_valid is up.
  // busy_req keeps req_valid high with addr 1F for the whole busy period.
  task automatic do_read(input logic [4:0] addr, input int hold, input bit busy_req);
    int p, s, pc, wc, sc, ov, lat, stall, k;
    bit done;
    logic [7:0] first_d, got, exp_d;
    p = sel ? 3 : 1;
    s = sel ? 4 : 2;
    pc = 0; wc = 0; sc = 0; ov = 0; lat = 0; stall = 0; done = 0; first_d = '0; got = '0;
    @(negedge clk);
    check("accept_ready", o_req_ready, 1);
    req_valid = 1'b1; req_addr = addr; rsp_ready = 1'b1;
    sb.push_back(mem[addr]);
    @(posedge clk);
    @(negedge clk);
    if (busy_req) req_addr = 5'h1F; else req_valid = 1'b0;
    k = 1;
    while (!done && k <= 40) begin
      pc += int'(o_pc);
      wc += int'(o_wl);
      sc += int'(o_sa);
      if (o_pc && (o_wl || o_sa)) ov++;
      if (o_rsp_valid) begin
        if (lat == 0) begin
          lat = k;
          first_d = o_rsp_data;
          req_valid = 1'b0;
        end
        check("rsp_data_stable", o_rsp_data, first_d);
        check("req_ready_low_in_resp", o_req_ready, 0);
        if (stall < hold) begin
          rsp_ready = 1'b0;
          stall++;
        end else begin
          rsp_ready = 1'b1;
          got = o_rsp_data;
          done = 1;
        end
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    rsp_ready = 1'b1;
    if (!done) begin
      check("rsp_timeout", 0, 1);
    end else begin
      exp_d = sb.pop_front();
      check("rsp_data", got, exp_d);
    end
    check("latency_cycles", lat, p + s + 2);
    check("precharge_cycles", pc, p);
    check("wl_cycles", wc, s + 1);
    check("sa_cycles", sc, 1);
    check("pc_wl_overlap", ov, 0);
    check("stall_cycles", stall, hold);
    check("post_rsp_valid", o_rsp_valid, 0);
    check("post_req_ready", o_req_ready, 1);
    check("post_busy", o_busy, 0);
    check("post_wl_addr", o_wl_addr, addr);
  endtask

  // Wait for the next response on the selected instance and score it at the handshake.
  task automatic wait_resp();
    bit seen;
    logic [7:0] exp_d;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (o_rsp_valid && rsp_ready) begin
        seen = 1;
        exp_d = sb.pop_front();
        check("b2b_rsp_data", o_rsp_data, exp_d);
      end
    end
    if (!seen) check("b2b_timeout", 0, 1);
  endtask

  initial begin
    int n;
    bit seen;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 3);
    mem[10] = 8'hA5;
    mem[5]  = 8'h3C;
    mem[0]  = 8'h5A;
    mem[31] = 8'hC3;
    sel = 0; rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", {a_req_ready, b_req_ready}, 2'b11);
    check("rst_busy", {a_busy, b_busy}, 0);
    check("rst_enables", {a_pc, a_wl, a_sa, b_pc, b_wl, b_sa}, 0);
    check("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
    check("rst_rsp_data", {a_rsp_data, b_rsp_data}, 0);
    check("rst_wl_addr", {a_wl_addr, b_wl_addr}, 0);

    // basic read, then backpressure
    do_read(5'h0A, 0, 0);
    do_read(5'h05, 5, 0);

    // request held during busy with a different address must not start a second read
    do_read(5'h03, 0, 1);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(o_rsp_valid) + int'(o_busy);
    end
    check("busy_req_no_extra", n, 0);
    check("busy_req_wl_addr", o_wl_addr, 5'h03);

    // reset in the middle of WORDLINE
    @(negedge clk);
    req_valid = 1'b1; req_addr = 5'h07;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (o_wl && !o_sa) seen = 1; else @(negedge clk);
    end
    check("reach_wordline", seen, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_enables", {o_pc, o_wl, o_sa}, 0);
    check("midrst_idle", {o_busy, o_req_ready, o_rsp_valid}, 3'b010);
    check("midrst_wl_addr", o_wl_addr, 0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      n += int'(o_rsp_valid);
    end
    check("midrst_no_rsp", n, 0);

    // back-to-back with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_addr = 5'h00;
    sb.push_back(mem[0]);
    wait_resp();
    req_addr = 5'h1F;
    sb.push_back(mem[31]);
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle_after_hs", {o_req_ready, o_busy}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    check("b2b_second_accept", {o_req_ready, o_busy, o_pc}, 3'b011);
    check("b2b_wl_addr", o_wl_addr, 5'h1F);
    req_valid = 1'b0;
    wait_resp();
    @(negedge clk);
    check("b2b_done", {o_req_ready, o_busy, o_rsp_valid}, 3'b100);

    // parameter sweep instance
    sel = 1;
    do_read(5'h11, 0, 0);
    do_read(5'h0A, 2, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
